// File: rtl/fsic_wbs_dispatcher.sv
// Wishbone slave dispatcher for the FSIC user area.
// One classic-cycle access at a time, routed to a one-hot target request.
module fsic_wbs_dispatcher #(
  parameter int          NUM_TGT  = 4,
  parameter logic [15:0] BASE_HI  = 16'h3000,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wbs_cyc,
  input  logic                    wbs_stb,
  input  logic                    wbs_we,
  input  logic [3:0]              wbs_sel,
  input  logic [31:0]             wbs_adr,
  input  logic [31:0]             wbs_wdata,
  output logic                    wbs_ack,
  output logic [31:0]             wbs_rdata,
  output logic [NUM_TGT-1:0]      tgt_req,
  output logic                    tgt_we,
  output logic [3:0]              tgt_sel,
  output logic [11:0]             tgt_addr,
  output logic [31:0]             tgt_wdata,
  input  logic [NUM_TGT-1:0]      tgt_ack,
  input  logic [32*NUM_TGT-1:0]   tgt_rdata,
  output logic                    busy,
  output logic                    timeout_pulse
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [CW-1:0]   cnt;
  logic            start;
  logic            hit;
  logic            ack_sel;
  logic            last;
  logic            tmo;
  logic [31:0]     sel_rdata;

  assign start   = wbs_cyc & wbs_stb;
  assign hit     = (wbs_adr[31:16] == BASE_HI) &&
                   (32'(wbs_adr[15:12]) < NUM_TGT);
  assign ack_sel = |(tgt_ack & tgt_req);
  assign last    = (cnt == CW'(TIMEOUT - 1));
  assign busy    = (state != IDLE);

  // tgt_req is one-hot, so OR-ing the gated lanes is a clean mux
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (tgt_req[i]) sel_rdata = sel_rdata | tgt_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_d = hit ? REQ : RESP;
      end
      REQ: begin
        if (ack_sel) begin
          state_d = RESP;
        end else if (last) begin
          state_d = RESP;
          tmo     = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wbs_ack       <= 1'b0;
      wbs_rdata     <= '0;
      tgt_req       <= '0;
      tgt_we        <= 1'b0;
      tgt_sel       <= '0;
      tgt_addr      <= '0;
      tgt_wdata     <= '0;
      timeout_pulse <= 1'b0;
      cnt           <= '0;
    end else begin
      wbs_ack       <= (state_d == RESP);
      timeout_pulse <= tmo;
      if (state == IDLE && start) begin
        tgt_we    <= wbs_we;
        tgt_sel   <= wbs_sel;
        tgt_addr  <= wbs_adr[11:0];
        tgt_wdata <= wbs_wdata;
        cnt       <= '0;
        if (hit) tgt_req <= NUM_TGT'(1) << wbs_adr[15:12];
        else     wbs_rdata <= '0;
      end
      if (state == REQ) begin
        if (!last) cnt <= cnt + 1'b1;
        if (ack_sel) begin
          wbs_rdata <= sel_rdata;
          tgt_req   <= '0;
        end else if (last) begin
          wbs_rdata <= ERR_DATA;
          tgt_req   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsic_wbs_dispatcher.sv
// Directed vector bench for fsic_wbs_dispatcher.
// NUM_TGT=4, TIMEOUT=8; target acks modelled per vector.
module tb_fsic_wbs_dispatcher;

  localparam int NT  = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wbs_cyc = 1'b0;
  logic          wbs_stb = 1'b0;
  logic          wbs_we = 1'b0;
  logic [3:0]    wbs_sel = '0;
  logic [31:0]   wbs_adr = '0;
  logic [31:0]   wbs_wdata = '0;
  logic          wbs_ack;
  logic [31:0]   wbs_rdata;
  logic [NT-1:0] tgt_req;
  logic          tgt_we;
  logic [3:0]    tgt_sel;
  logic [11:0]   tgt_addr;
  logic [31:0]   tgt_wdata;
  logic [NT-1:0] tgt_ack = '0;
  logic [32*NT-1:0] tgt_rdata = '0;
  logic          busy;
  logic          timeout_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsic_wbs_dispatcher #(
    .NUM_TGT (NT),
    .BASE_HI (16'h3000),
    .TIMEOUT (TMO),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk       (clk),
    .wb_rst       (rst),
    .wbs_cyc      (wbs_cyc),
    .wbs_stb      (wbs_stb),
    .wbs_we       (wbs_we),
    .wbs_sel      (wbs_sel),
    .wbs_adr      (wbs_adr),
    .wbs_wdata    (wbs_wdata),
    .wbs_ack      (wbs_ack),
    .wbs_rdata    (wbs_rdata),
    .tgt_req      (tgt_req),
    .tgt_we       (tgt_we),
    .tgt_sel      (tgt_sel),
    .tgt_addr     (tgt_addr),
    .tgt_wdata    (tgt_wdata),
    .tgt_ack      (tgt_ack),
    .tgt_rdata    (tgt_rdata),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          dly;
    int          tgt;
    logic [3:0]  stray;
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] exp_rdata;
    int          lat;
    logic        tmo;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int m;
    int reqc;
    logic seen;
    @(negedge clk);
    wbs_cyc   = 1'b1;
    wbs_stb   = 1'b1;
    wbs_we    = v.we;
    wbs_sel   = v.sel;
    wbs_adr   = v.adr;
    wbs_wdata = v.wdata;
    for (int i = 0; i < NT; i++)
      tgt_rdata[32*i +: 32] = (i == v.tgt) ? v.rdata : 32'h3333_3300 + i;
    @(posedge clk); #1;
    if (v.hit) begin
      chk("req_onehot", 32'(tgt_req), 32'(1) << v.tgt);
      chk("tgt_addr", 32'(tgt_addr), 32'(v.adr[11:0]));
      chk("tgt_we", 32'(tgt_we), 32'(v.we));
      chk("tgt_sel", 32'(tgt_sel), 32'(v.sel));
      chk("tgt_wdata", tgt_wdata, v.wdata);
    end else begin
      chk("miss_noreq", 32'(tgt_req), 32'd0);
    end
    m = 0;
    reqc = 0;
    seen = 1'b0;
    while (!seen && m < 40) begin
      if (wbs_ack) begin
        seen = 1'b1;
      end else begin
        tgt_ack = '0;
        if (tgt_req != '0) begin
          tgt_ack = v.stray;
          if (reqc == v.dly) tgt_ack[v.tgt] = 1'b1;
          reqc++;
        end
        @(posedge clk); #1;
        m++;
      end
    end
    tgt_ack = '0;
    chk("ack_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(m + 1), 32'(v.lat));
      chk("req_cycles", 32'(reqc), v.hit ? 32'(v.lat - 1) : 32'd0);
      chk("rdata", wbs_rdata, v.exp_rdata);
      chk("timeout_pulse", 32'(timeout_pulse), 32'(v.tmo));
      chk("busy_resp", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
    chk("ack_one_cycle", 32'(wbs_ack), 32'd0);
    chk("req_cleared", 32'(tgt_req), 32'd0);
    chk("tmo_one_cycle", 32'(timeout_pulse), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("rdata_hold", wbs_rdata, v.exp_rdata);
  endtask

  initial begin
    vecs[0] = '{32'h3000_2010, 1'b0, 4'hF, 32'h0, 3, 2, 4'b1000,
                32'h1234_5678, 1'b1, 32'h1234_5678, 5, 1'b0};
    vecs[1] = '{32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_0001, 0, 0, 4'b0,
                32'h0000_1111, 1'b1, 32'h0000_1111, 2, 1'b0};
    vecs[2] = '{32'h3000_5000, 1'b0, 4'hF, 32'h0, -1, 0, 4'b0,
                32'h5555_5555, 1'b0, 32'h0, 1, 1'b0};
    vecs[3] = '{32'h2000_0000, 1'b1, 4'hF, 32'h1, -1, 0, 4'b0,
                32'h6666_6666, 1'b0, 32'h0, 1, 1'b0};
    vecs[4] = '{32'h3000_1008, 1'b0, 4'hF, 32'h0, -1, 1, 4'b0,
                32'h7777_7777, 1'b1, 32'hDEAD_BEEF, TMO + 1, 1'b1};
    vecs[5] = '{32'h3000_1020, 1'b0, 4'hF, 32'h0, TMO - 1, 1, 4'b1000,
                32'hCAFE_0001, 1'b1, 32'hCAFE_0001, TMO + 1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wbs_ack), 32'd0);
    chk("rst_rdata", wbs_rdata, 32'd0);
    chk("rst_req", 32'(tgt_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tgt_fields", {15'd0, tgt_we, tgt_sel, tgt_addr}, 32'd0);
    chk("rst_wdata", tgt_wdata, 32'd0);
    chk("rst_tmo", 32'(timeout_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // abandon an outstanding request with an asynchronous reset
    @(negedge clk);
    wbs_cyc = 1'b1;
    wbs_stb = 1'b1;
    wbs_we  = 1'b0;
    wbs_adr = 32'h3000_3000;
    tgt_ack = '0;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #2;
    chk("mid_req_high", 32'(tgt_req), 32'h8);
    chk("mid_busy_high", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_req", 32'(tgt_req), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ack", 32'(wbs_ack), 32'd0);
    wbs_cyc = 1'b0;
    wbs_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(vecs[0]);
    run(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsic_wbs_dispatcher.md
Name: fsic_wbs_dispatcher

Overview:
Sequences the management-SoC Wishbone slave port of the FSIC user area onto up to NUM_TGT internal register targets. It decodes each classic-cycle Wishbone access and drives exactly one target request. It then waits for that target's acknowledge, or times out, and returns a single registered wbs_ack with read data. It sits between the user_project_wrapper Wishbone pins and the FSIC register/config blocks, and only one access is outstanding at a time.

Parameters:
NUM_TGT, 4, number of targets (1..16); target index = wbs_adr[15:12]
BASE_HI, 16'h3000, required value of wbs_adr[31:16] (user-area window)
TIMEOUT, 255, maximum wait for tgt_ack in cycles (>=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
wb_clk  in  1  clock
wb_rst  in  1  reset; asynchronous, active-high
wbs_cyc  in  1  Wishbone cycle
wbs_stb  in  1  Wishbone strobe
wbs_we  in  1  write enable
wbs_sel  in  4  byte selects
wbs_adr  in  32  byte address
wbs_wdata  in  32  write data
wbs_ack  out  1  acknowledge, one-cycle pulse
wbs_rdata  out  32  read data, valid while wbs_ack=1
tgt_req  out  NUM_TGT  one-hot request, held until ack/timeout
tgt_we  out  1  latched wbs_we
tgt_sel  out  4  latched wbs_sel
tgt_addr  out  12  latched wbs_adr[11:0]
tgt_wdata  out  32  latched wbs_wdata
tgt_ack  in  NUM_TGT  per-target acknowledge (single-cycle or level)
tgt_rdata  in  32*NUM_TGT  flattened read data; target i at [32*i+31:32*i]
busy  out  1  high in any state other than IDLE
timeout_pulse  out  1  one-cycle pulse when a timeout response is issued

Behaviour:
- Reset values (asserted asynchronously): state=IDLE; wbs_ack=0; wbs_rdata=0; tgt_req=0; tgt_we=0; tgt_sel=0; tgt_addr=0; tgt_wdata=0; busy=0; timeout_pulse=0; counter=0.
- Reset mid-transaction drops tgt_req immediately and abandons the access. No ack is issued.
- States: IDLE, REQ, RESP.
- IDLE, when wbs_cyc&wbs_stb:
  - Latch we/sel/adr[11:0]/wdata.
  - Hit = (adr[31:16]==BASE_HI) and (adr[15:12] < NUM_TGT).
  - Hit -> REQ, with tgt_req[adr[15:12]]=1 from the next cycle; counter=0.
  - Miss -> RESP with rdata latched = 0. No target is touched.
- REQ:
  - tgt_req stays constant. Counter increments each cycle.
  - The selected tgt_ack=1 -> capture that target's tgt_rdata into wbs_rdata (write: capture regardless); clear tgt_req; -> RESP.
  - Acks from non-selected targets are ignored.
  - Counter==TIMEOUT-1 with no ack -> wbs_rdata=ERR_DATA; clear tgt_req; timeout_pulse=1 for one cycle; -> RESP.
  - Ack and timeout in the same cycle: the ack wins and there is no timeout_pulse.
- RESP: wbs_ack=1 for exactly one cycle; -> IDLE. wbs_rdata holds its value until the next capture.
- Latency:
  - Hit with target ack in its first REQ cycle: wbs_ack 2 cycles after stb is sampled in IDLE.
  - Miss: wbs_ack 1 cycle after sampling.
  - Timeout: wbs_ack TIMEOUT+1 cycles after sampling.
- The master must drop stb in the cycle after wbs_ack. IDLE re-samples stb on the first cycle back, so there is no dead cycle.
- wbs_cyc/stb dropped during REQ: the access still completes to the target and ack is issued (the master ignores it). No abort.
- Counter width = $clog2(TIMEOUT+1); it never wraps, because it saturates and exits at TIMEOUT-1.
- Only one request is outstanding, and tgt_req is always one-hot or zero.

Test Plan:
1. Read target 2: adr=0x3000_2010, tgt_ack[2] pulses 3 cycles after tgt_req[2] rises with rdata 0x1234_5678 -> tgt_addr=0x010; wbs_ack exactly one cycle with wbs_rdata=0x1234_5678; tgt_req=0 afterwards.
2. Write target 0 with ack in the first REQ cycle: adr=0x3000_0004, wdata=0xA5A5_0001, sel=4'b0011 -> tgt_we=1, tgt_wdata/sel latched; wbs_ack 2 cycles after stb sampled.
3. Unmapped accesses: adr=0x3000_5000 (NUM_TGT=4) and adr=0x2000_0000 -> no tgt_req; wbs_ack 1 cycle later with rdata=0.
4. Timeout, TIMEOUT=8: the target never acks -> tgt_req high 8 cycles; timeout_pulse=1 and wbs_rdata=0xDEAD_BEEF; wbs_ack the following cycle.
5. Ack on the timeout cycle plus a stray ack: tgt_ack[1] asserted at counter==TIMEOUT-1 -> real rdata returned, no timeout_pulse; a simultaneous tgt_ack[3] has no effect.
6. Async reset during REQ: wb_rst asserted mid-wait -> tgt_req, busy, wbs_ack go 0 without a clock edge. After release, a back-to-back read completes normally.
